// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard unit and the EXE-stage operand muxes:
// datapath sizes, FSM state encodings, forward-select codes and the
// scoreboard slot layout.
package hazard_ctrl_pkg;

  localparam int ASIZE = 5;
  localparam int DSIZE = 32;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_e;

  // Operand select seen by the EXE-stage muxes.
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_e;

  typedef struct packed {
    logic             wen;
    logic             mem_read;
    logic [ASIZE-1:0] waddr;
  } sb_slot_t;

  // A slot produces a value for this source only if it writes a real register.
  function automatic logic slot_hit(sb_slot_t s, logic src_used, logic [ASIZE-1:0] rs);
    return s.wen && (s.waddr != '0) && src_used && (s.waddr == rs);
  endfunction

  // Nearest producer wins; a load in EX cannot forward (the consumer is
  // bubbled instead), and WB needs no bypass because the regfile is write-through.
  function automatic fwd_e fwd_sel(sb_slot_t ex, sb_slot_t mem, sb_slot_t wb,
                                   logic src_used, logic [ASIZE-1:0] rs);
    if (slot_hit(ex, src_used, rs))  return ex.mem_read ? FWD_RF : FWD_EXMEM;
    if (slot_hit(mem, src_used, rs)) return FWD_MEMWB;
    if (slot_hit(wb, src_used, rs))  return FWD_RF;
    return FWD_RF;
  endfunction

  function automatic logic [15:0] sat_inc(logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard unit signal bundle. The pipeline (master) presents the
// ID/EX instruction info; the hazard unit (slave) returns pipeline control.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [ASIZE-1:0] id_rs1;
  logic [ASIZE-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             id_wen;
  logic             id_mem_read;
  logic [ASIZE-1:0] id_waddr;
  logic             ex_branch;
  logic             ex_taken;

  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             idex_bubble;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [15:0]      stall_cnt;
  logic [15:0]      flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_wen, id_mem_read,
           id_waddr, ex_branch, ex_taken,
    input  pc_stall, ifid_stall, ifid_flush, idex_bubble, fwd_a, fwd_b,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_wen, id_mem_read,
           id_waddr, ex_branch, ex_taken,
    output pc_stall, ifid_stall, ifid_flush, idex_bubble, fwd_a, fwd_b,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_scoreboard.sv
// Three-slot destination scoreboard (EX, MEM, WB) that shifts every clock.
// A bubble loads an empty record into EX instead of the ID instruction.
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     bubble_i,
  input  sb_slot_t id_slot_i,
  output sb_slot_t ex_o,
  output sb_slot_t mem_o,
  output sb_slot_t wb_o
);

  sb_slot_t ex_q, mem_q, wb_q;
  sb_slot_t ex_d;

  // Select what enters EX: the ID instruction or an empty bubble.
  always_comb begin
    ex_d = bubble_i ? '0 : id_slot_i;
  end

  // Shift register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  assign ex_o  = ex_q;
  assign mem_o = mem_q;
  assign wb_o  = wb_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit: load-use stall, taken-branch flush, operand forwarding
// selects for the instruction entering EX, and saturating event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  hazard_ctrl_if.slave hz
);

  state_e      state_q, state_d;
  logic [1:0]  fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic     pc_stall_c, ifid_stall_c, ifid_flush_c, idex_bubble_c;
  logic     id_valid, use1, use2, taken, load_use;
  sb_slot_t id_slot, ex_slot, mem_slot, wb_slot;

  assign id_slot = '{wen: hz.id_wen, mem_read: hz.id_mem_read, waddr: hz.id_waddr};

  hazard_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .bubble_i (idex_bubble_c),
    .id_slot_i(id_slot),
    .ex_o     (ex_slot),
    .mem_o    (mem_slot),
    .wb_o     (wb_slot)
  );

  // The instruction in ID during FLUSH is a wrong-path fetch.
  assign id_valid = (state_q != ST_FLUSH);
  assign use1     = hz.id_use_rs1 && id_valid;
  assign use2     = hz.id_use_rs2 && id_valid;
  assign taken    = hz.ex_branch && hz.ex_taken;
  assign load_use = ex_slot.mem_read &&
                    (slot_hit(ex_slot, use1, hz.id_rs1) || slot_hit(ex_slot, use2, hz.id_rs2));

  // Next state, pipeline control, forward selects and counter updates.
  always_comb begin
    state_d       = state_q;
    pc_stall_c    = 1'b0;
    ifid_stall_c  = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;

    case (state_q)
      ST_RUN:  if (taken) state_d = ST_FLUSH;
               else if (load_use) state_d = ST_STALL;
      default: state_d = ST_RUN;
    endcase

    // A taken branch squashes the consumer, so it overrides any stall.
    if (taken) begin
      ifid_flush_c  = 1'b1;
      idex_bubble_c = 1'b1;
    end else if (load_use) begin
      pc_stall_c    = 1'b1;
      ifid_stall_c  = 1'b1;
      idex_bubble_c = 1'b1;
    end
    if (state_q == ST_FLUSH) idex_bubble_c = 1'b1;

    if (!rst) begin
      pc_stall_c    = 1'b0;
      ifid_stall_c  = 1'b0;
      ifid_flush_c  = 1'b0;
      idex_bubble_c = 1'b0;
    end

    fwd_a_d = idex_bubble_c ? FWD_RF : fwd_sel(ex_slot, mem_slot, wb_slot, use1, hz.id_rs1);
    fwd_b_d = idex_bubble_c ? FWD_RF : fwd_sel(ex_slot, mem_slot, wb_slot, use2, hz.id_rs2);

    stall_cnt_d = (load_use && !taken) ? sat_inc(stall_cnt_q) : stall_cnt_q;
    flush_cnt_d = taken ? sat_inc(flush_cnt_q) : flush_cnt_q;
  end

  // State, forward-select and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.pc_stall    = pc_stall_c;
  assign hz.ifid_stall  = ifid_stall_c;
  assign hz.ifid_flush  = ifid_flush_c;
  assign hz.idex_bubble = idex_bubble_c;
  assign hz.fwd_a       = fwd_a_q;
  assign hz.fwd_b       = fwd_b_q;
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: instruction-stream vector table with expected
// control and forward selects, plus reset-in-stall and counter saturation.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  typedef struct packed {
    logic [ASIZE-1:0] rs1, rs2;
    logic             u1, u2, wen, mr;
    logic [ASIZE-1:0] wa;
    logic             br, tk;
    logic [3:0]       ctl;   // {pc_stall, ifid_stall, ifid_flush, idex_bubble}
    logic [1:0]       fa, fb;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  logic [3:0] exp_q[$];
  vec_t tbl[22];

  hazard_ctrl_if hz();

  hazard_ctrl dut (
    .clk(clk),
    .rst(rst),
    .hz (hz.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int rs1, int rs2, int u1, int u2, int wen, int mr, int wa,
                              int br, int tk, int ctl, int fa, int fb);
    vec_t v;
    v.rs1 = ASIZE'(rs1); v.rs2 = ASIZE'(rs2);
    v.u1 = (u1 != 0); v.u2 = (u2 != 0); v.wen = (wen != 0); v.mr = (mr != 0);
    v.wa = ASIZE'(wa); v.br = (br != 0); v.tk = (tk != 0);
    v.ctl = 4'(ctl); v.fa = 2'(fa); v.fb = 2'(fb);
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    hz.id_rs1 = v.rs1;  hz.id_rs2 = v.rs2;
    hz.id_use_rs1 = v.u1; hz.id_use_rs2 = v.u2;
    hz.id_wen = v.wen;  hz.id_mem_read = v.mr; hz.id_waddr = v.wa;
    hz.ex_branch = v.br; hz.ex_taken = v.tk;
  endtask

  // Drive one ID cycle, check control mid-cycle, check fwd after the edge.
  task automatic apply(input string nm, input vec_t v);
    logic [3:0] e;
    drive(v);
    #1;
    check({nm, " ctl"}, {28'd0, hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.idex_bubble},
          {28'd0, v.ctl});
    exp_q.push_back({v.fa, v.fb});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({nm, " fwd"}, {28'd0, hz.fwd_a, hz.fwd_b}, {28'd0, e});
  endtask

  initial begin
    //              rs1 rs2 u1 u2 wen mr wa  br tk ctl      fa fb
    tbl[0]  = mk(1,  0,  1, 0, 1, 1, 3,  0, 0, 4'b0000, 0, 0); // lw r3
    tbl[1]  = mk(3,  5,  1, 1, 1, 0, 4,  0, 0, 4'b1101, 0, 0); // add r4=r3+r5: load-use
    tbl[2]  = mk(3,  5,  1, 1, 1, 0, 4,  0, 0, 4'b0000, 2, 0); // STALL: re-eval, MEM hit
    tbl[3]  = mk(0,  0,  0, 0, 1, 0, 2,  0, 0, 4'b0000, 0, 0); // add r2
    tbl[4]  = mk(2,  2,  1, 1, 1, 0, 6,  0, 0, 4'b0000, 1, 1); // sub r6=r2-r2
    tbl[5]  = mk(0,  0,  0, 0, 1, 0, 2,  0, 0, 4'b0000, 0, 0); // add r2
    tbl[6]  = mk(0,  0,  0, 0, 0, 0, 0,  0, 0, 4'b0000, 0, 0); // nop
    tbl[7]  = mk(2,  1,  1, 1, 1, 0, 7,  0, 0, 4'b0000, 2, 0); // or r7=r2|r1
    tbl[8]  = mk(2,  7,  1, 1, 1, 0, 9,  0, 0, 4'b0000, 0, 1); // r2 three apart, r7 adjacent
    tbl[9]  = mk(0,  0,  0, 0, 1, 0, 0,  0, 0, 4'b0000, 0, 0); // write r0
    tbl[10] = mk(0,  0,  1, 1, 1, 0, 10, 0, 0, 4'b0000, 0, 0); // read r0
    tbl[11] = mk(0,  0,  0, 0, 1, 1, 0,  0, 0, 4'b0000, 0, 0); // lw r0
    tbl[12] = mk(0,  0,  1, 1, 0, 0, 0,  0, 0, 4'b0000, 0, 0); // read r0: no stall
    tbl[13] = mk(0,  0,  0, 0, 1, 1, 5,  0, 0, 4'b0000, 0, 0); // lw r5
    tbl[14] = mk(5,  0,  1, 0, 1, 0, 13, 1, 1, 4'b0011, 0, 0); // load-use + taken branch
    tbl[15] = mk(5,  0,  1, 0, 1, 0, 13, 0, 0, 4'b0001, 0, 0); // FLUSH: ID invalid
    tbl[16] = mk(0,  0,  0, 0, 1, 1, 11, 0, 1, 4'b0000, 0, 0); // lw r11, taken w/o branch
    tbl[17] = mk(0,  11, 0, 1, 1, 0, 14, 0, 1, 4'b1101, 0, 0); // load-use on rs2
    tbl[18] = mk(0,  11, 0, 1, 1, 0, 14, 0, 0, 4'b0000, 0, 2); // STALL: fwd_b=10
    tbl[19] = mk(0,  0,  0, 0, 1, 1, 12, 0, 0, 4'b0000, 0, 0); // lw r12
    tbl[20] = mk(12, 12, 0, 0, 1, 0, 15, 0, 0, 4'b0000, 0, 0); // address match, not used
    tbl[21] = mk(0,  0,  0, 0, 0, 0, 0,  0, 0, 4'b0000, 0, 0); // nop

    // Reset state: async clear before any clock edge; a taken branch is
    // presented to show the combinational controls are held low.
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("reset ctl", {28'd0, hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.idex_bubble}, 32'd0);
    check("reset fwd", {28'd0, hz.fwd_a, hz.fwd_b}, 32'd0);
    check("reset cnt", {hz.stall_cnt, hz.flush_cnt}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;

    for (int i = 0; i < 22; i++) apply($sformatf("vec%0d", i), tbl[i]);
    check("stall_cnt after table", {16'd0, hz.stall_cnt}, 32'd2);
    check("flush_cnt after table", {16'd0, hz.flush_cnt}, 32'd1);

    // Reset asserted asynchronously while in STALL.
    apply("rs lw r3", mk(0, 0, 0, 0, 1, 1, 3, 0, 0, 4'b0000, 0, 0));
    apply("rs use r3", mk(3, 0, 1, 0, 1, 0, 4, 0, 0, 4'b1101, 0, 0));
    hz.ex_branch = 1'b1;
    hz.ex_taken  = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("stall rst ctl", {28'd0, hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.idex_bubble}, 32'd0);
    check("stall rst fwd", {28'd0, hz.fwd_a, hz.fwd_b}, 32'd0);
    check("stall rst cnt", {hz.stall_cnt, hz.flush_cnt}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    apply("post rst", mk(3, 0, 1, 0, 1, 0, 4, 0, 0, 4'b0000, 0, 0));
    check("post rst cnt", {hz.stall_cnt, hz.flush_cnt}, 32'd0);

    // Flush counter saturation over 65536 taken branches.
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    repeat (65534) @(posedge clk);
    #1;
    check("flush_cnt 65534", {16'd0, hz.flush_cnt}, 32'h0000FFFE);
    @(posedge clk);
    #1;
    check("flush_cnt 65535", {16'd0, hz.flush_cnt}, 32'h0000FFFF);
    @(posedge clk);
    #1;
    check("flush_cnt sat", {16'd0, hz.flush_cnt}, 32'h0000FFFF);
    check("stall_cnt idle", {16'd0, hz.stall_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
